// File: rtl/weight_row_loader.sv
// Weight row loader: packs a stream of weight words into full RAM rows and
// writes one row per NROW accepted words until all NCOL rows are stored.
module weight_row_loader #(
  parameter int NROW     = 16,
  parameter int NCOL     = 16,
  parameter int BITWIDTH = 18,
  localparam int ADDR_BITWIDTH = (NCOL > 1) ? $clog2(NCOL) : 1,
  localparam int ROW_SIZE      = BITWIDTH * NROW
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [BITWIDTH-1:0]      wordIn,
  input  logic                     wordValid,
  output logic                     wordReady,
  output logic [ADDR_BITWIDTH-1:0] addressIn,
  output logic                     writeEn,
  output logic [ROW_SIZE-1:0]      rowIn,
  output logic                     busy,
  output logic                     done
);

  localparam int CNT_W = (NROW > 1) ? $clog2(NROW) : 1;
  localparam logic [CNT_W-1:0]         LAST_WORD = CNT_W'(NROW - 1);
  localparam logic [ADDR_BITWIDTH-1:0] LAST_ROW  = ADDR_BITWIDTH'(NCOL - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                   state;
  logic [CNT_W-1:0]         wordCnt;
  logic [ADDR_BITWIDTH-1:0] rowCnt;
  logic [ROW_SIZE-1:0]      packBuf;
  logic [ROW_SIZE-1:0]      packNext;

  // Only FILL consumes words; decoded from the registered state.
  assign wordReady = (state == FILL);

  // Row buffer with the incoming word dropped into its slot, so the last word
  // of a row can go straight into the registered rowIn output.
  always_comb begin
    packNext = packBuf;
    packNext[int'(wordCnt) * BITWIDTH +: BITWIDTH] = wordIn;
  end

  // Load sequencer: counters, packing buffer and all registered outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      wordCnt   <= '0;
      rowCnt    <= '0;
      packBuf   <= '0;
      writeEn   <= 1'b0;
      addressIn <= '0;
      rowIn     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= FILL;
            wordCnt <= '0;
            rowCnt  <= '0;
            busy    <= 1'b1;
          end
        end
        FILL: begin
          if (wordValid) begin
            packBuf <= packNext;
            if (wordCnt == LAST_WORD) begin
              // Row complete: the write strobe is high for the WRITE cycle.
              wordCnt   <= '0;
              state     <= WRITE;
              writeEn   <= 1'b1;
              addressIn <= rowCnt;
              rowIn     <= packNext;
            end else begin
              wordCnt <= wordCnt + 1'b1;
            end
          end
        end
        WRITE: begin
          writeEn <= 1'b0;
          if (rowCnt == LAST_ROW) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            rowCnt <= rowCnt + 1'b1;
            state  <= FILL;
          end
        end
        DONE: begin
          // A start seen here is dropped; only IDLE reacts to start.
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_row_loader.sv
// Self-checking bench for weight_row_loader (NROW=4, NCOL=2, BITWIDTH=18).
// Expected row writes are queued when words are driven and popped when the
// DUT strobes writeEn.
module tb_weight_row_loader;

  localparam int NROW = 4;
  localparam int NCOL = 2;
  localparam int BW   = 18;
  localparam int RS   = NROW * BW;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [BW-1:0] wordIn;
  logic          wordValid;
  logic          wordReady;
  logic [0:0]    addressIn;
  logic          writeEn;
  logic [RS-1:0] rowIn;
  logic          busy;
  logic          done;

  weight_row_loader #(.NROW(NROW), .NCOL(NCOL), .BITWIDTH(BW)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .wordIn   (wordIn),
    .wordValid(wordValid),
    .wordReady(wordReady),
    .addressIn(addressIn),
    .writeEn  (writeEn),
    .rowIn    (rowIn),
    .busy     (busy),
    .done     (done)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lastWrCyc = 0;
  int doneCyc = 0;

  logic [0:0]    expAddr[$];
  logic [RS-1:0] expRow[$];
  logic [BW-1:0] wl[8];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkVal(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Write monitor: every strobe must match the oldest queued row.
  always @(negedge clock) begin
    if (writeEn === 1'b1) begin
      lastWrCyc = cyc;
      if (expRow.size() == 0) begin
        checkVal("unexpected_write", 80'(1), 80'(0));
      end else begin
        checkVal("wr_addr", 80'(addressIn), 80'(expAddr.pop_front()));
        checkVal("wr_row", 80'(rowIn), 80'(expRow.pop_front()));
      end
    end
    if (done === 1'b1) doneCyc = cyc;
  end

  task automatic runLoad(input bit bubble, input int startAt, input bit startOnDone, input int nWords);
    int firstCyc;
    int guard;
    logic [RS-1:0] r;
    for (int row = 0; row < NCOL; row++) begin
      if (row * NROW + NROW - 1 < nWords) begin
        for (int k = 0; k < NROW; k++) r[k*BW +: BW] = wl[row*NROW + k];
        expAddr.push_back(1'(row));
        expRow.push_back(r);
      end
    end
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    firstCyc = 0;
    for (int k = 0; k < nWords; k++) begin
      if (bubble && k > 0) begin
        wordValid = 1'b0;
        @(negedge clock);
      end
      wordValid = 1'b1;
      wordIn = wl[k];
      guard = 0;
      while (wordReady !== 1'b1 && guard < 20) begin
        @(negedge clock);
        guard++;
      end
      if (guard >= 20) checkVal("ready_timeout", 80'(0), 80'(1));
      if (k == 0) firstCyc = cyc;
      if (k == startAt) start = 1'b1;
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
    end
    wordValid = 1'b0;

    if (nWords < NROW * NCOL) begin
      reset = 1'b0;
      @(posedge clock);
      @(negedge clock);
      checkVal("rst_busy", 80'(busy), 80'(0));
      checkVal("rst_ready", 80'(wordReady), 80'(0));
      checkVal("rst_wen", 80'(writeEn), 80'(0));
      checkVal("rst_done", 80'(done), 80'(0));
      checkVal("rst_addr", 80'(addressIn), 80'(0));
      checkVal("rst_row", 80'(rowIn), 80'(0));
      reset = 1'b1;
      wordValid = 1'b1;
      repeat (6) @(negedge clock);
      checkVal("no_resume_busy", 80'(busy), 80'(0));
      checkVal("no_resume_ready", 80'(wordReady), 80'(0));
      wordValid = 1'b0;
      checkVal("rst_queue_empty", 80'(expRow.size()), 80'(0));
      return;
    end

    guard = 0;
    while (done !== 1'b1 && guard < 30) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 30) begin
      checkVal("done_timeout", 80'(0), 80'(1));
    end else begin
      if (!bubble) checkVal("load_cycles", 80'(cyc - firstCyc + 1), 80'(NCOL * (NROW + 1) + 1));
      checkVal("done_after_write", 80'(cyc - lastWrCyc), 80'(1));
    end
    if (startOnDone) start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    checkVal("done_pulse", 80'(done), 80'(0));
    checkVal("idle_busy", 80'(busy), 80'(0));
    checkVal("idle_ready", 80'(wordReady), 80'(0));
    checkVal("queue_empty", 80'(expRow.size()), 80'(0));
    repeat (3) @(negedge clock);
    checkVal("still_idle", 80'(busy), 80'(0));
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    wordValid = 1'b0;
    wordIn = '0;
    repeat (2) @(negedge clock);
    checkVal("reset_wen", 80'(writeEn), 80'(0));
    checkVal("reset_done", 80'(done), 80'(0));
    checkVal("reset_busy", 80'(busy), 80'(0));
    checkVal("reset_ready", 80'(wordReady), 80'(0));
    checkVal("reset_addr", 80'(addressIn), 80'(0));
    checkVal("reset_row", 80'(rowIn), 80'(0));
    reset = 1'b1;
    @(negedge clock);

    // Basic load, words 1..8 back to back.
    for (int i = 0; i < 8; i++) wl[i] = BW'(i + 1);
    runLoad(1'b0, -1, 1'b0, 8);
    // Same data with a gap between every word.
    runLoad(1'b1, -1, 1'b0, 8);
    // A second start in the middle of FILL must be ignored.
    runLoad(1'b0, 2, 1'b0, 8);
    // Reset after six accepted words, then a fresh load of 9..16.
    runLoad(1'b0, -1, 1'b0, 6);
    for (int i = 0; i < 8; i++) wl[i] = BW'(i + 9);
    runLoad(1'b0, -1, 1'b0, 8);
    // Full-scale and zero words alternating; start arrives with done.
    for (int i = 0; i < 8; i++) wl[i] = (i % 2 == 0) ? 18'h3FFFF : 18'h00000;
    runLoad(1'b0, -1, 1'b1, 8);
    wl[0] = 18'h00000; wl[1] = 18'h3FFFF; wl[2] = 18'h00000; wl[3] = 18'h3FFFF;
    wl[4] = 18'h3FFFF; wl[5] = 18'h00000; wl[6] = 18'h3FFFF; wl[7] = 18'h00000;
    runLoad(1'b1, -1, 1'b0, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/weight_row_loader.md
WEIGHT_ROW_LOADER -- requirements
Module: weight_row_loader

Interface
REQ-001 SHALL have parameter NROW, default 16, words per RAM row.
REQ-002 SHALL have parameter NCOL, default 16, rows per matrix, which is also the RAM depth.
REQ-003 SHALL have parameter BITWIDTH, default 18, bits per weight word.
REQ-004 SHALL derive ADDR_BITWIDTH = log2(NCOL) and ROW_SIZE = BITWIDTH*NROW; neither is user-set.
REQ-005 SHALL have port clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-007 SHALL have port start, input, 1 bit: a one-cycle pulse that begins a full-matrix load.
REQ-008 SHALL have port wordIn, input, BITWIDTH bits: streamed weight word.
REQ-009 SHALL have port wordValid, input, 1 bit: wordIn is valid.
REQ-010 SHALL have port wordReady, output, 1 bit: the loader accepts wordIn.
REQ-011 SHALL have port addressIn, output, ADDR_BITWIDTH bits: RAM write row address.
REQ-012 SHALL have port writeEn, output, 1 bit: RAM write strobe.
REQ-013 SHALL have port rowIn, output, ROW_SIZE bits: packed row written to the RAM.
REQ-014 SHALL have port busy, output, 1 bit: a load is in progress.
REQ-015 SHALL have port done, output, 1 bit: one-cycle pulse when the last row has been written.

Function
REQ-016 SHALL implement the FSM states IDLE, FILL, WRITE and DONE.
REQ-017 In IDLE, start=1 SHALL move to FILL on the next edge and clear the word and row counters to 0; start outside IDLE SHALL be ignored.
REQ-018 wordReady SHALL equal (state==FILL), decoded combinationally from registered state.
REQ-019 A word SHALL be accepted only on a cycle with wordValid=1 and wordReady=1; a cycle with wordValid=0 changes nothing.
REQ-020 The k-th accepted word of a row (k = 0..NROW-1) SHALL land in packed bits [k*BITWIDTH +: BITWIDTH], with word 0 at the LSBs.
REQ-021 Acceptance of word NROW-1 SHALL move FILL to WRITE; the word counter SHALL wrap to 0.
REQ-022 In WRITE, writeEn SHALL be 1 for exactly that one cycle, with addressIn = row counter and rowIn = the fully packed row; writeEn SHALL therefore rise on the cycle after the last word of the row is accepted.
REQ-023 writeEn, addressIn and rowIn SHALL be registered outputs.
REQ-024 addressIn and rowIn SHALL hold their last values while writeEn=0.
REQ-025 From WRITE, if row counter < NCOL-1, the FSM SHALL increment the row counter and return to FILL.
REQ-026 From WRITE, if row counter == NCOL-1, the FSM SHALL go to DONE.
REQ-027 DONE SHALL assert done for one cycle and then return to IDLE; the row counter SHALL not wrap past NCOL-1.
REQ-028 busy SHALL be 1 in FILL, WRITE and DONE, and 0 in IDLE.
REQ-029 Sustained throughput SHALL be NROW+1 cycles per row with wordValid held at 1; a full load therefore takes NCOL*(NROW+1)+1 cycles from the first accepted word to done.
REQ-030 A start pulse arriving in the same cycle as done SHALL be ignored.
REQ-031 writeEn SHALL never assert outside WRITE, and never twice for the same row address within one load.

Reset
REQ-032 reset=0 at a rising edge SHALL force IDLE and clear the counters.
REQ-033 On that reset, outputs SHALL go to writeEn=0, done=0, busy=0, addressIn=0 and rowIn=0, with wordReady=0 in the same cycle.
REQ-034 A reset during FILL or WRITE SHALL discard the partial row and cancel any pending write; no writeEn SHALL follow the reset.
REQ-035 After reset release, operation SHALL resume only on a new start pulse.

Verification (bench parameters: NROW=4, NCOL=2, BITWIDTH=18)
REQ-036 Basic load: start, then words 1..8 with wordValid held at 1 -> writeEn at addr 0 with rowIn = {4,3,2,1}; writeEn at addr 1 with rowIn = {8,7,6,5}; done one cycle after the second write; 11 cycles from the first accept to done.
REQ-037 Bubbles: wordValid toggled 1,0,1,0,... with the same data -> identical rowIn values to REQ-036; writeEn never asserts during gaps.
REQ-038 Ignored start: start pulsed again mid-FILL -> no counter reset; output identical to REQ-036.
REQ-039 Reset mid-operation: reset=0 after word 6 is accepted -> busy=0 and wordReady=0 on the next cycle; no further writeEn; a new start followed by words 9..16 writes {12,11,10,9} to addr 0 and {16,15,14,13} to addr 1.
REQ-040 Width extremes: words 0x3FFFF and 0x00000 alternating -> each field is exact with no bleed between adjacent words; done=1 for exactly one cycle, then IDLE.
